// File: rtl/target.sv
// Shootable circular target: sweeps horizontally while alive (only when TARGET_MOVE_EN is defined), scores hits, respawns after a cooldown.
// hit/score/alive update one cycle after the shot; render lags (x,y) by one cycle; there is no backpressure.
module target #(
    parameter int RADIUS        = 16,
    parameter int MOVE_TICKS    = 499_999,
    parameter int RESPAWN_TICKS = 24_999_999,
    parameter int SCORE_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         x,
    input  logic [8:0]         y,
    input  logic               shot,
    input  logic [9:0]         shoot_x,
    input  logic [8:0]         shoot_y,
    output logic               hit,
    output logic               alive,
    output logic [SCORE_W-1:0] score,
    output logic               render
);

    localparam logic [20:0] R_SQ = 21'(RADIUS * RADIUS);
    localparam int          RC_W = $clog2(RESPAWN_TICKS + 1);

    typedef enum logic [0:0] {S_ALIVE, S_DEAD} state_t;

    state_t             state_q, state_d;
    logic [9:0]         tx_q, tx_d;
    logic [8:0]         ty_q, ty_d;
    logic               hit_q, hit_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               render_q, render_d;
    logic [RC_W-1:0]    resp_q, resp_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic               shot_in, pix_in;

`ifdef TARGET_MOVE_EN
    localparam int         MC_W   = $clog2(MOVE_TICKS + 1);
    localparam logic [9:0] TX_MIN = 10'(RADIUS);
    localparam logic [9:0] TX_MAX = 10'(639 - RADIUS);
    logic [MC_W-1:0] mcnt_q, mcnt_d;
    logic            dir_q, dir_d;   // 1 = moving right
`endif

    // Inclusive circle test on a point relative to the centre (cx,cy).
    function automatic logic in_circle(input logic [9:0] px, input logic [8:0] py,
                                       input logic [9:0] cx, input logic [8:0] cy);
        logic signed [10:0] dx, dy;
        logic [10:0]        ndx, ndy;
        logic [9:0]         ax, ay;
        logic [19:0]        sx, sy;
        logic [20:0]        sum;
        dx  = $signed({1'b0, px}) - $signed({1'b0, cx});
        dy  = $signed({2'b0, py}) - $signed({2'b0, cy});
        ndx = -dx;
        ndy = -dy;
        ax  = dx[10] ? ndx[9:0] : dx[9:0];
        ay  = dy[10] ? ndy[9:0] : dy[9:0];
        sx  = {10'b0, ax} * {10'b0, ax};
        sy  = {10'b0, ay} * {10'b0, ay};
        sum = {1'b0, sx} + {1'b0, sy};
        return sum <= R_SQ;
    endfunction

    assign alive   = (state_q == S_ALIVE);
    assign shot_in = in_circle(shoot_x, shoot_y, tx_q, ty_q);
    assign pix_in  = in_circle(x, y, tx_q, ty_q);

    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        ty_d     = ty_q;
        hit_d    = 1'b0;
        score_d  = score_q;
        resp_d   = resp_q;
        render_d = alive && pix_in;
        lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`ifdef TARGET_MOVE_EN
        mcnt_d   = mcnt_q;
        dir_d    = dir_q;
`endif
        case (state_q)
            S_ALIVE: begin
                if (shot && shot_in) begin
                    hit_d   = 1'b1;
                    state_d = S_DEAD;
                    resp_d  = '0;
                    if (score_q != {SCORE_W{1'b1}})
                        score_d = score_q + SCORE_W'(1);
                end
`ifdef TARGET_MOVE_EN
                // Edges flip direction on arrival so tx never leaves the legal band.
                if (mcnt_q == MC_W'(MOVE_TICKS - 1)) begin
                    mcnt_d = '0;
                    if (dir_q) begin
                        if (tx_q < TX_MAX) tx_d = tx_q + 10'd1;
                        if (tx_q >= TX_MAX - 10'd1) dir_d = 1'b0;
                    end else begin
                        if (tx_q > TX_MIN) tx_d = tx_q - 10'd1;
                        if (tx_q <= TX_MIN + 10'd1) dir_d = 1'b1;
                    end
                end else begin
                    mcnt_d = mcnt_q + MC_W'(1);
                end
`endif
            end
            S_DEAD: begin
                resp_d = resp_q + RC_W'(1);
                if (resp_q == RC_W'(RESPAWN_TICKS)) begin
                    state_d = S_ALIVE;
                    resp_d  = '0;
                    tx_d    = 10'(RADIUS) + {1'b0, lfsr_q[8:0]};
                    ty_d    = 9'(RADIUS) + {1'b0, lfsr_q[15:8]};
                end
            end
            default: state_d = S_ALIVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_ALIVE;
            tx_q     <= 10'd320;
            ty_q     <= 9'd240;
            hit_q    <= 1'b0;
            score_q  <= '0;
            render_q <= 1'b0;
            resp_q   <= '0;
            lfsr_q   <= 16'hACE1;
`ifdef TARGET_MOVE_EN
            mcnt_q   <= '0;
            dir_q    <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            ty_q     <= ty_d;
            hit_q    <= hit_d;
            score_q  <= score_d;
            render_q <= render_d;
            resp_q   <= resp_d;
            lfsr_q   <= lfsr_d;
`ifdef TARGET_MOVE_EN
            mcnt_q   <= mcnt_d;
            dir_q    <= dir_d;
`endif
        end
    end

    assign hit    = hit_q;
    assign score  = score_q;
    assign render = render_q;

endmodule

// File: tb/tb_target.sv
// Directed bench for target with RADIUS=16, MOVE_TICKS=4, RESPAWN_TICKS=8.
// A second instance with SCORE_W=2 shares all inputs to exercise score saturation.
module tb_target;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] x;
    logic [8:0] y;
    logic       shot;
    logic [9:0] shoot_x;
    logic [8:0] shoot_y;
    logic       hit, alive, render;
    logic [7:0] score;
    logic       hit2, alive2, render2;
    logic [1:0] score2;

    int total = 0;
    int bad   = 0;

    logic [15:0] lfsr_m;

    always #5 clk = ~clk;

    target #(.RADIUS(16), .MOVE_TICKS(4), .RESPAWN_TICKS(8), .SCORE_W(8)) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .shot(shot),
        .shoot_x(shoot_x), .shoot_y(shoot_y),
        .hit(hit), .alive(alive), .score(score), .render(render)
    );

    target #(.RADIUS(16), .MOVE_TICKS(4), .RESPAWN_TICKS(8), .SCORE_W(2)) dut2 (
        .clk(clk), .reset(reset), .x(x), .y(y), .shot(shot),
        .shoot_x(shoot_x), .shoot_y(shoot_y),
        .hit(hit2), .alive(alive2), .score(score2), .render(render2)
    );

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed ACE1.
    always @(posedge clk) begin
        if (reset) lfsr_m <= 16'hACE1;
        else       lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        shot  = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; shot = 1'b0; x = 10'd0; y = 9'd0; shoot_x = 10'd0; shoot_y = 9'd0;
        tick(); tick();
        total++; if (alive !== 1'b1)   begin bad++; $display("FAIL reset_alive got=%b exp=1", alive); end
        total++; if (score !== 8'd0)   begin bad++; $display("FAIL reset_score got=%0d exp=0", score); end
        total++; if (hit !== 1'b0)     begin bad++; $display("FAIL reset_hit got=%b exp=0", hit); end
        total++; if (render !== 1'b0)  begin bad++; $display("FAIL reset_render got=%b exp=0", render); end
        reset = 1'b0;
        x = 10'd320; y = 9'd240;
        tick();
        total++; if (render !== 1'b1)  begin bad++; $display("FAIL render_centre got=%b exp=1", render); end
        x = 10'd340;
        tick();
        total++; if (render !== 1'b0)  begin bad++; $display("FAIL render_outside got=%b exp=0", render); end
    endtask

    task automatic test_hit_respawn();
        logic [15:0] l;
        logic [9:0]  px;
        logic [8:0]  py;
        do_reset();
        shoot_x = 10'd320; shoot_y = 9'd240; shot = 1'b1;
        tick();
        total++; if (hit !== 1'b1)   begin bad++; $display("FAIL hit_pulse got=%b exp=1", hit); end
        total++; if (score !== 8'd1) begin bad++; $display("FAIL hit_score got=%0d exp=1", score); end
        total++; if (alive !== 1'b0) begin bad++; $display("FAIL hit_alive got=%b exp=0", alive); end
        for (int i = 1; i <= 8; i++) begin
            tick();
            total++; if (hit !== 1'b0 || alive !== 1'b0)
                begin bad++; $display("FAIL dead_cycle%0d hit=%b alive=%b exp hit=0 alive=0", i, hit, alive); end
        end
        total++; if (score !== 8'd1) begin bad++; $display("FAIL dead_score got=%0d exp=1", score); end
        l = lfsr_m;
        tick();  // respawn edge, shot still held at the old position
        total++; if (alive !== 1'b1) begin bad++; $display("FAIL respawn_alive got=%b exp=1", alive); end
        total++; if (hit !== 1'b0 || score !== 8'd1)
            begin bad++; $display("FAIL respawn_shot_ignored hit=%b score=%0d exp hit=0 score=1", hit, score); end
        shot = 1'b0;
        px = 10'd16 + {1'b0, l[8:0]};
        py = 9'd16 + {1'b0, l[15:8]};
        x = px; y = py;
        tick();
        total++; if (render !== 1'b1) begin bad++; $display("FAIL respawn_pos render got=%b exp=1 at (%0d,%0d)", render, px, py); end
    endtask

    task automatic test_radius();
        logic [9:0] sx [6] = '{10'd336, 10'd337, 10'd331, 10'd320, 10'd320, 10'd304};
        logic [8:0] sy [6] = '{9'd240,  9'd240,  9'd251,  9'd256,  9'd257,  9'd240};
        logic       ex [6] = '{1'b1,    1'b0,    1'b1,    1'b1,    1'b0,    1'b1};
        for (int i = 0; i < 6; i++) begin
            do_reset();
            shoot_x = sx[i]; shoot_y = sy[i]; shot = 1'b1;
            tick();
            shot = 1'b0;
            total++; if (hit !== ex[i] || score !== {7'd0, ex[i]} || alive !== !ex[i])
                begin bad++; $display("FAIL radius(%0d,%0d) hit=%b score=%0d alive=%b exp hit=%b",
                                      sx[i], sy[i], hit, score, alive, ex[i]); end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] l;
        logic [1:0]  exp_s;
        do_reset();
        shoot_x = 10'd320; shoot_y = 9'd240; shot = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            tick();
            shot = 1'b0;
            exp_s = (n >= 3) ? 2'd3 : 2'(n);
            total++; if (hit2 !== 1'b1 || score2 !== exp_s)
                begin bad++; $display("FAIL sat_hit%0d hit=%b score=%0d exp hit=1 score=%0d", n, hit2, score2, exp_s); end
            repeat (8) tick();
            l = lfsr_m;
            tick();
            shoot_x = 10'd16 + {1'b0, l[8:0]};
            shoot_y = 9'd16 + {1'b0, l[15:8]};
            shot = 1'b1;
        end
        shot = 1'b0;
        total++; if (score !== 8'd5) begin bad++; $display("FAIL wide_score got=%0d exp=5", score); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        shoot_x = 10'd320; shoot_y = 9'd240; shot = 1'b1;
        tick();
        shot = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (hit !== 1'b0 || alive !== 1'b1 || score !== 8'd0)
            begin bad++; $display("FAIL reset_during_hit hit=%b alive=%b score=%0d exp 0/1/0", hit, alive, score); end
        shot = 1'b1;
        tick();
        shot = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (alive !== 1'b1 || score !== 8'd0 || hit !== 1'b0)
            begin bad++; $display("FAIL reset_in_dead alive=%b score=%0d hit=%b exp 1/0/0", alive, score, hit); end
        x = 10'd320; y = 9'd240;
        tick();
        total++; if (render !== 1'b1) begin bad++; $display("FAIL reset_pos_centre render=%b exp=1", render); end
        x = 10'd337;
        tick();
        total++; if (render !== 1'b0) begin bad++; $display("FAIL reset_pos_edge render=%b exp=0", render); end
    endtask

`ifdef TARGET_MOVE_EN
    task automatic test_move();
        int  bad_cycles = 0;
        logic exp_r;
        do_reset();
        y = 9'd240;
        for (int k = 1; k <= 1300; k++) begin
            case (k)
                41:      begin x = 10'd346; exp_r = 1'b1; end  // tx=330 after 40 cycles
                42:      begin x = 10'd314; exp_r = 1'b1; end
                1213:    begin x = 10'd639; exp_r = 1'b1; end  // tx=623 at right edge
                1217:    begin x = 10'd606; exp_r = 1'b1; end  // turned back to 622
                default: begin x = 10'd640; exp_r = 1'b0; end  // tx never exceeds 623
            endcase
            tick();
            if (render !== exp_r) begin
                if (bad_cycles == 0)
                    $display("FAIL move_cycle%0d render=%b exp=%b x=%0d", k, render, exp_r, x);
                bad_cycles++;
            end
        end
        total++; if (bad_cycles != 0) begin bad++; $display("FAIL move_sweep bad_cycles=%0d exp=0", bad_cycles); end
    endtask
`endif

    initial begin
        test_reset();
        test_hit_respawn();
        test_radius();
        test_saturation();
        test_reset_mid();
`ifdef TARGET_MOVE_EN
        test_move();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/target.md
# target

Shootable target for the shooter game, sitting downstream of the gun block and consuming its shot event (`shot`, `shoot_x`, `shoot_y`).
- While alive, it optionally sweeps horizontally across the 640x480 screen.
- On a shot it tests whether the shot lands inside its circle. A hit pulses `hit`, bumps a saturating score, and removes the target for a respawn cooldown.
- After the cooldown it reappears at a pseudo-random position.
- It also drives a per-pixel `render` signal for the VGA mixer.

## Interface
Parameters:
- RADIUS, 16: hit/draw radius in pixels; the test is inclusive (dx²+dy² ≤ RADIUS²).
- MOVE_TICKS, 499_999: clock cycles per 1-pixel horizontal step.
- RESPAWN_TICKS, 24_999_999: clock cycles spent dead before respawn.
- SCORE_W, 8: score counter width.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- x  in  10  current VGA pixel column
- y  in  9  current VGA pixel row
- shot  in  1  one-cycle shot event from gun
- shoot_x  in  10  shot column, valid when shot=1
- shoot_y  in  9  shot row, valid when shot=1
- hit  out  1  one-cycle pulse: the shot hit the target
- alive  out  1  target is present and shootable
- score  out  SCORE_W  number of hits, saturating
- render  out  1  pixel (x,y) lies inside the live target (registered)

## Operation
- State machine:
  - S_ALIVE: `alive`=1. Moves; accepts shots.
  - S_DEAD: `alive`=0. Frozen; shots ignored; a respawn counter increments every cycle.
- Hit test, combinational on the current position (tx,ty):
  - dx = shoot_x − tx and dy = shoot_y − ty, each 11-bit signed.
  - dx² and dy² are 20-bit unsigned; the sum is 21-bit.
  - Compare the sum to RADIUS² zero-extended to 21 bits; the comparison is inclusive.
- Shot while in S_ALIVE and inside the circle:
  - `hit` is registered to 1.
  - `score` increments; it saturates at 2^SCORE_W−1 and never wraps.
  - State goes to S_DEAD and the respawn counter clears.
- Shot while in S_ALIVE and outside the circle: no effect.
- Shot while in S_DEAD: ignored entirely; no hit and no score change.
- Leaving S_DEAD:
  - Happens when the respawn counter reaches RESPAWN_TICKS.
  - tx ← RADIUS + lfsr[8:0], giving the range [16, 527].
  - ty ← RADIUS + lfsr[15:8], giving the range [16, 271].
  - State goes to S_ALIVE and the direction is unchanged.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Steps every cycle regardless of state.
- Movement (S_ALIVE only):
  - The move counter counts 0..MOVE_TICKS−1; on wrap, tx steps ±1 according to dir.
  - If tx reaches 639−RADIUS while moving right, dir flips to left in the same cycle.
  - If tx reaches RADIUS while moving left, dir flips to right in the same cycle.
  - tx therefore never leaves [RADIUS, 639−RADIUS].
  - ty is constant while alive.
  - The move counter holds in S_DEAD.
- Render: same circle test applied to (x,y), ANDed with `alive`.
- Simultaneous events:
  - A shot on the same cycle as a movement step is tested against the pre-step position.
  - A respawn cycle coinciding with a shot: the shot is ignored, because the state is still S_DEAD.

## Timing
- Reset values:
  - State S_ALIVE, so `alive`=1.
  - (tx,ty) = (320,240), dir = right.
  - `hit`=0, `score`=0, `render`=0.
  - Move counter, respawn counter and LFSR = 16'hACE1.
- Shot accepted in cycle N:
  - `hit`=1 during N+1 only.
  - `score` updated and `alive`=0 in N+1.
- Respawn counter increments from 0 starting in N+1.
  - `alive` returns to 1 RESPAWN_TICKS+1 cycles after N+1.
- `render` lags (x,y) by exactly 1 cycle.
- Reset mid-operation, including in S_DEAD or while `hit` is high: all state returns to reset values on the next edge. The score is lost.

## Configuration
- TARGET_MOVE_EN:
  - Defined: horizontal sweep as described.
  - Undefined: no move counter or direction logic. tx stays at its reset or respawn value, so the target is stationary while alive.
  - All other behaviour is identical in both builds.

## Test plan
Bench parameters: RADIUS=16, MOVE_TICKS=4, RESPAWN_TICKS=8. Build without TARGET_MOVE_EN unless stated.
1. Reset → `alive`=1, `score`=0, `hit`=0. x=320, y=240 presented → `render`=1 next cycle; x=340 → `render`=0.
2. `shot` at (320,240) → `hit`=1 for exactly one cycle, `score`=1, `alive`=0. Repeat shots for 8 cycles → no `hit`, `score` stays 1. `alive`=1 after 9 cycles, with tx in [16,527] and ty in [16,271].
3. Radius boundary:
   - `shot` at (336,240) → hit (dx=16).
   - After reset, `shot` at (337,240) → no hit.
   - After reset, `shot` at (331,251) → hit (121+121 ≤ 256).
4. With TARGET_MOVE_EN defined:
   - After 40 cycles from reset → tx=330.
   - Force a run to the right edge → tx reaches 623, then decreases; never exceeds 623.
5. Score saturation: SCORE_W=2, 5 successful hits with respawns in between → `score` sequence 1,2,3,3,3.
6. Reset asserted in S_DEAD, 3 cycles after a hit → next cycle `alive`=1, `score`=0, target at (320,240).
